// File: rtl/control_unit.sv
// Decode/sequence stage behind the IR: drives PC control and datapath enables.
// Latency: ALU ops 1 cycle, loads 2 cycles, MUL/DIV/MOD wait for alu_done (bounded by ALU_TIMEOUT).
// Backpressure: stall holds the PC (and so the IR) while a load or long ALU op is outstanding.
module control_unit #(
  parameter int OPW         = 6,
  parameter int VALW        = 8,
  parameter int ADDRW       = 10,
  parameter int ALU_TIMEOUT = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OPW-1:0]   op_code,
  input  logic             reg_s,
  input  logic             acc_s,
  input  logic [VALW-1:0]  val,
  input  logic             zero,
  input  logic             neg,
  input  logic             carry,
  input  logic             ovf,
  input  logic             alu_done,
  output logic             stall,
  output logic             branch,
  output logic [ADDRW-1:0] br_address,
  output logic [OPW-1:0]   alu_op,
  output logic             alu_start,
  output logic             reg_we,
  output logic             acc_we,
  output logic             mem_re,
  output logic             mem_we,
  output logic             halted,
  output logic             illegal,
  output logic             timeout
);

  // Wait counter only needs to reach ALU_TIMEOUT-1.
  localparam int CNTW = (ALU_TIMEOUT > 2) ? $clog2(ALU_TIMEOUT) : 1;
  localparam logic [CNTW-1:0] CNT_LIM = CNTW'(ALU_TIMEOUT - 1);

  // Opcode map
  localparam logic [OPW-1:0] OP_HLT     = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_LDR     = OPW'(6'b000001);
  localparam logic [OPW-1:0] OP_STR     = OPW'(6'b000010);
  localparam logic [OPW-1:0] OP_BRZ     = OPW'(6'b000011);
  localparam logic [OPW-1:0] OP_BRN     = OPW'(6'b000100);
  localparam logic [OPW-1:0] OP_BRC     = OPW'(6'b000101);
  localparam logic [OPW-1:0] OP_BRO     = OPW'(6'b000110);
  localparam logic [OPW-1:0] OP_BRA     = OPW'(6'b000111);
  localparam logic [OPW-1:0] OP_ALU_LO  = OPW'(6'b001000);
  localparam logic [OPW-1:0] OP_ALU_HI  = OPW'(6'b001111);
  localparam logic [OPW-1:0] OP_MUL     = OPW'(6'b010000);
  localparam logic [OPW-1:0] OP_DIV     = OPW'(6'b010001);
  localparam logic [OPW-1:0] OP_MOD     = OPW'(6'b010010);

  typedef enum logic [2:0] {
    ST_START    = 3'd0,
    ST_EXEC     = 3'd1,
    ST_MEM_WAIT = 3'd2,
    ST_ALU_WAIT = 3'd3,
    ST_FLUSH    = 3'd4,
    ST_HALT     = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [OPW-1:0]  alu_op_q, alu_op_d;

  // Instruction class decode of the current IR contents
  logic is_alu;
  logic is_mdm;
  logic is_cond_br;
  logic br_taken;

  // Classify the opcode and resolve branch direction from the ALU flags
  always_comb begin
    is_alu     = (op_code >= OP_ALU_LO) && (op_code <= OP_ALU_HI);
    is_mdm     = (op_code == OP_MUL) || (op_code == OP_DIV) || (op_code == OP_MOD);
    is_cond_br = (op_code >= OP_BRZ) && (op_code <= OP_BRA);
    br_taken   = 1'b0;
    case (op_code)
      OP_BRZ:  br_taken = zero;
      OP_BRN:  br_taken = neg;
      OP_BRC:  br_taken = carry;
      OP_BRO:  br_taken = ovf;
      OP_BRA:  br_taken = 1'b1;
      default: br_taken = 1'b0;
    endcase
  end

  // Next-state, counter and combinational output decode of state + IR
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    alu_op_d  = alu_op_q;
    stall     = 1'b0;
    branch    = 1'b0;
    alu_start = 1'b0;
    reg_we    = 1'b0;
    acc_we    = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    halted    = 1'b0;
    illegal   = 1'b0;
    timeout   = 1'b0;

    case (state_q)
      ST_START: begin
        // Give the IR one cycle to fill before decoding.
        stall   = 1'b1;
        state_d = ST_EXEC;
      end

      ST_EXEC: begin
        alu_op_d = op_code;
        if (is_alu) begin
          acc_we = ~reg_s;
          reg_we = reg_s;
        end else if (op_code == OP_LDR) begin
          mem_re  = 1'b1;
          stall   = 1'b1;
          state_d = ST_MEM_WAIT;
        end else if (op_code == OP_STR) begin
          mem_we = 1'b1;
        end else if (is_cond_br) begin
          // Not-taken branches fall through as a NOP.
          if (br_taken) begin
            branch  = 1'b1;
            state_d = ST_FLUSH;
          end
        end else if (is_mdm) begin
          alu_start = 1'b1;
          stall     = 1'b1;
          cnt_d     = '0;
          state_d   = ST_ALU_WAIT;
        end else if (op_code == OP_HLT) begin
          // Hold the PC so nothing past the HLT is fetched.
          stall   = 1'b1;
          state_d = ST_HALT;
        end else begin
          illegal = 1'b1;
        end
      end

      ST_MEM_WAIT: begin
        // Load data returns now; write it back and release the PC.
        mem_re  = 1'b1;
        acc_we  = ~reg_s;
        reg_we  = reg_s;
        state_d = ST_EXEC;
      end

      ST_ALU_WAIT: begin
        cnt_d = cnt_q + CNTW'(1);
        if (alu_done) begin
          // A result arriving on the limit cycle still counts.
          acc_we  = ~reg_s;
          reg_we  = reg_s;
          cnt_d   = '0;
          state_d = ST_EXEC;
        end else if (cnt_q == CNT_LIM) begin
          // Abandon the instruction: release the PC so it is skipped,
          // otherwise EXEC would just reissue it.
          timeout = 1'b1;
          cnt_d   = '0;
          state_d = ST_EXEC;
        end else begin
          stall = 1'b1;
        end
      end

      ST_FLUSH: begin
        // IR holds the wrong-path instruction; drop it.
        state_d = ST_EXEC;
      end

      ST_HALT: begin
        stall  = 1'b1;
        halted = 1'b1;
      end

      default: begin
        stall   = 1'b1;
        state_d = ST_START;
      end
    endcase

    // Reset dominates: no enables escape in the reset cycle.
    if (reset) begin
      stall     = 1'b1;
      branch    = 1'b0;
      alu_start = 1'b0;
      reg_we    = 1'b0;
      acc_we    = 1'b0;
      mem_re    = 1'b0;
      mem_we    = 1'b0;
      halted    = 1'b0;
      illegal   = 1'b0;
      timeout   = 1'b0;
    end
  end

  // State, wait counter and registered ALU opcode
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_START;
      cnt_q    <= '0;
      alu_op_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      alu_op_q <= alu_op_d;
    end
  end

  assign alu_op     = alu_op_q;
  assign br_address = ADDRW'({acc_s, reg_s, val});

  // PC must never be told to both hold and load.
  a_stall_branch_excl: assert property (@(posedge clk) !(stall && branch));

  // Write enables are one-hot when present.
  a_we_onehot: assert property (@(posedge clk) !(reg_we && acc_we));

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: each cycle applies an IR word and flags,
// then compares the packed output vector against a hand-computed constant.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op_code;
  logic       reg_s;
  logic       acc_s;
  logic [7:0] val;
  logic       zero, neg, carry, ovf;
  logic       alu_done;
  logic       stall, branch, alu_start, reg_we, acc_we;
  logic       mem_re, mem_we, halted, illegal, timeout;
  logic [9:0] br_address;
  logic [5:0] alu_op;

  int n_cmp = 0;
  int n_err = 0;

  // Output vector bit weights
  localparam logic [9:0] S  = 10'h200; // stall
  localparam logic [9:0] BR = 10'h100; // branch
  localparam logic [9:0] AS = 10'h080; // alu_start
  localparam logic [9:0] RW = 10'h040; // reg_we
  localparam logic [9:0] AW = 10'h020; // acc_we
  localparam logic [9:0] MR = 10'h010; // mem_re
  localparam logic [9:0] MW = 10'h008; // mem_we
  localparam logic [9:0] H  = 10'h004; // halted
  localparam logic [9:0] IL = 10'h002; // illegal
  localparam logic [9:0] TO = 10'h001; // timeout
  localparam logic [9:0] NONE = 10'h000;

  logic [9:0] outs;
  assign outs = {stall, branch, alu_start, reg_we, acc_we, mem_re, mem_we, halted, illegal, timeout};

  control_unit #(.OPW(6), .VALW(8), .ADDRW(10), .ALU_TIMEOUT(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .op_code    (op_code),
    .reg_s      (reg_s),
    .acc_s      (acc_s),
    .val        (val),
    .zero       (zero),
    .neg        (neg),
    .carry      (carry),
    .ovf        (ovf),
    .alu_done   (alu_done),
    .stall      (stall),
    .branch     (branch),
    .br_address (br_address),
    .alu_op     (alu_op),
    .alu_start  (alu_start),
    .reg_we     (reg_we),
    .acc_we     (acc_we),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .halted     (halted),
    .illegal    (illegal),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the IR fields and let the combinational decode settle.
  task automatic apply(input logic [5:0] op, input logic rs, input logic as, input logic [7:0] v);
    op_code = op;
    reg_s   = rs;
    acc_s   = as;
    val     = v;
    #2;
  endtask

  task automatic expect_outs(input string tag, input logic [9:0] exp);
    check_eq(tag, 32'(outs), 32'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; op_code = '0; reg_s = 1'b0; acc_s = 1'b0; val = '0;
    zero = 1'b0; neg = 1'b0; carry = 1'b0; ovf = 1'b0; alu_done = 1'b0;

    // Reset held two cycles
    tick(); apply(6'b001010, 1'b0, 1'b0, 8'h00);
    expect_outs("reset_c1", S);
    check_eq("reset_alu_op", 32'(alu_op), 32'd0);
    tick(); apply(6'b001010, 1'b0, 1'b0, 8'h00);
    expect_outs("reset_c2", S);

    // Release: START stalls one cycle
    reset = 1'b0;
    apply(6'b001010, 1'b0, 1'b0, 8'h00);
    expect_outs("start", S);
    tick();

    // Single-cycle ALU to accumulator; alu_done here is ignored
    alu_done = 1'b1;
    apply(6'b001010, 1'b0, 1'b0, 8'h00);
    expect_outs("alu_acc", AW);
    alu_done = 1'b0;
    tick();
    check_eq("alu_op_reg", 32'(alu_op), 32'h0A);

    // Single-cycle ALU to register
    apply(6'b001111, 1'b1, 1'b0, 8'h00);
    expect_outs("alu_reg", RW);
    tick();

    // LDR 000001_0_0_00001101: two cycles, PC advances once
    apply(6'b000001, 1'b0, 1'b0, 8'h0D);
    expect_outs("ldr_c1", MR | S);
    tick();
    apply(6'b000001, 1'b0, 1'b0, 8'h0D);
    expect_outs("ldr_c2", MR | AW);
    tick();

    // STR with stray alu_done
    alu_done = 1'b1;
    apply(6'b000010, 1'b0, 1'b0, 8'h00);
    expect_outs("str", MW);
    alu_done = 1'b0;
    tick();

    // BRZ not taken
    zero = 1'b0;
    apply(6'b000011, 1'b0, 1'b1, 8'h14);
    expect_outs("brz_nt", NONE);
    tick();

    // BRZ taken, then FLUSH drops a wrong-path ALU op
    zero = 1'b1;
    apply(6'b000011, 1'b0, 1'b1, 8'h14);
    expect_outs("brz_t", BR);
    check_eq("br_address", 32'(br_address), 32'h214);
    tick();
    zero = 1'b0;
    apply(6'b001000, 1'b0, 1'b0, 8'h00);
    expect_outs("flush1", NONE);
    tick();

    // BRA right after FLUSH, then FLUSH drops a wrong-path HLT
    apply(6'b000111, 1'b1, 1'b0, 8'hA5);
    expect_outs("bra_after_flush", BR);
    check_eq("bra_addr", 32'(br_address), 32'h1A5);
    tick();
    apply(6'b000000, 1'b0, 1'b0, 8'h00);
    expect_outs("flush_hlt", NONE);
    tick();

    // BRN uses neg, not zero
    zero = 1'b1; neg = 1'b0;
    apply(6'b000100, 1'b0, 1'b0, 8'h00);
    expect_outs("brn_nt", NONE);
    tick();
    zero = 1'b0; carry = 1'b1;
    apply(6'b000101, 1'b0, 1'b0, 8'h33);
    expect_outs("brc_t", BR);
    tick();
    carry = 1'b0;
    apply(6'b001001, 1'b0, 1'b0, 8'h00);
    expect_outs("flush2", NONE);
    tick();
    ovf = 1'b1;
    apply(6'b000110, 1'b0, 1'b0, 8'h00);
    expect_outs("bro_t", BR);
    tick();
    ovf = 1'b0;
    apply(6'b000010, 1'b0, 1'b0, 8'h00);
    expect_outs("flush3", NONE);
    tick();

    // MUL, alu_done on the 5th ALU_WAIT cycle
    apply(6'b010000, 1'b0, 1'b0, 8'h00);
    expect_outs("mul_start", AS | S);
    tick();
    for (int i = 1; i <= 4; i++) begin
      apply(6'b010000, 1'b0, 1'b0, 8'h00);
      expect_outs($sformatf("mul_wait%0d", i), S);
      tick();
    end
    alu_done = 1'b1;
    apply(6'b010000, 1'b0, 1'b0, 8'h00);
    expect_outs("mul_done", AW);
    tick();
    alu_done = 1'b0;
    check_eq("mul_alu_op", 32'(alu_op), 32'h10);

    // DIV never completes: timeout on the 32nd ALU_WAIT cycle
    apply(6'b010001, 1'b1, 1'b0, 8'h00);
    expect_outs("div_start", AS | S);
    tick();
    for (int i = 1; i <= 31; i++) begin
      apply(6'b010001, 1'b1, 1'b0, 8'h00);
      expect_outs($sformatf("div_wait%0d", i), S);
      tick();
    end
    apply(6'b010001, 1'b1, 1'b0, 8'h00);
    expect_outs("div_timeout", TO);
    tick();

    // Back in EXEC after timeout
    apply(6'b001100, 1'b0, 1'b0, 8'h00);
    expect_outs("post_timeout", AW);
    tick();

    // Modulo op with alu_done on the limit cycle: done wins
    apply(6'b010010, 1'b1, 1'b0, 8'h00);
    expect_outs("mod_start", AS | S);
    tick();
    for (int i = 1; i <= 31; i++) begin
      apply(6'b010010, 1'b1, 1'b0, 8'h00);
      tick();
    end
    alu_done = 1'b1;
    apply(6'b010010, 1'b1, 1'b0, 8'h00);
    expect_outs("mod_done_at_limit", RW);
    tick();
    alu_done = 1'b0;

    // Illegal opcodes
    apply(6'b111111, 1'b0, 1'b0, 8'h00);
    expect_outs("illegal_3f", IL);
    tick();
    apply(6'b010011, 1'b1, 1'b0, 8'h00);
    expect_outs("illegal_13", IL);
    tick();

    // Reset during ALU_WAIT with a coincident alu_done
    apply(6'b010000, 1'b0, 1'b0, 8'h00);
    expect_outs("mul2_start", AS | S);
    tick();
    apply(6'b010000, 1'b0, 1'b0, 8'h00);
    tick();
    reset = 1'b1; alu_done = 1'b1;
    apply(6'b010000, 1'b0, 1'b0, 8'h00);
    expect_outs("reset_in_wait", S);
    tick();
    reset = 1'b0; alu_done = 1'b0;
    apply(6'b010000, 1'b0, 1'b0, 8'h00);
    expect_outs("start_after_abort", S);
    tick();

    // HLT then stays halted regardless of IR and alu_done
    apply(6'b000000, 1'b0, 1'b0, 8'h00);
    expect_outs("hlt_exec", S);
    tick();
    for (int i = 0; i < 5; i++) begin
      alu_done = i[0];
      apply(6'b001000 + 6'(i), i[1], 1'b0, 8'h00);
      expect_outs($sformatf("halted%0d", i), S | H);
      tick();
    end
    alu_done = 1'b0;

    // Only reset leaves HALT
    reset = 1'b1;
    apply(6'b001000, 1'b0, 1'b0, 8'h00);
    expect_outs("halt_reset", S);
    tick();
    reset = 1'b0;
    apply(6'b001000, 1'b0, 1'b0, 8'h00);
    expect_outs("halt_restart", S);
    tick();
    apply(6'b001000, 1'b0, 1'b0, 8'h00);
    expect_outs("resume_alu", AW);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
